// File: rtl/accu_group_arbiter_pkg.sv
// Shared types and defaults for the accumulator group arbiter slice.
package accu_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, WAIT_RES} arb_state_e;

    localparam int NUM_REQ_DEF   = 4;
    localparam int GROUP_LEN_DEF = 4;
    localparam int DATA_W_DEF    = 8;
    localparam int SUM_W_DEF     = 10;

    // Increment modulo n; used for the round-robin pointer.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/accu_group_arbiter_if.sv
// Requester-side streams, accumulator link and tagged result bus of the group arbiter.
interface accu_group_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int SUM_W   = 10
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      acc_valid_in;
    logic [DATA_W-1:0]         acc_data_in;
    logic                      acc_valid_out;
    logic [SUM_W-1:0]          acc_data_out;
    logic                      res_valid;
    logic [ID_W-1:0]           res_id;
    logic [SUM_W-1:0]          res_data;

    modport slave (
        input  req_valid, req_data, acc_valid_out, acc_data_out,
        output req_ready, acc_valid_in, acc_data_in, res_valid, res_id, res_data
    );

    modport master (
        output req_valid, req_data, acc_valid_out, acc_data_out,
        input  req_ready, acc_valid_in, acc_data_in, res_valid, res_id, res_data
    );

endinterface

// File: rtl/accu_group_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr, wrapping.
module accu_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [ID_W-1:0]    grant_id,
    output logic               any_req
);

    always_comb begin : pick
        int unsigned idx;
        logic [ID_W-1:0] idx_l;
        grant_id = '0;
        any_req  = 1'b0;
        idx      = 0;
        idx_l    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_l = ID_W'(idx);
            if (!any_req && req_valid[idx_l]) begin
                any_req  = 1'b1;
                grant_id = idx_l;
            end
        end
    end

endmodule

// File: rtl/accu_group_arbiter.sv
// Grants one 4-beat accumulator to a requester per group and returns the tagged sum.
// Optional per-requester completed-group counters under `ACCU_ARB_STATS_EN.
module accu_group_arbiter
    import accu_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int SUM_W     = SUM_W_DEF,
    parameter int GROUP_LEN = GROUP_LEN_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    accu_group_arbiter_if.slave   bus,
`ifdef ACCU_ARB_STATS_EN
    output logic [NUM_REQ*16-1:0] grp_cnt,
`endif
    output logic                  proto_err
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = (GROUP_LEN > 1) ? $clog2(GROUP_LEN) : 1;

    arb_state_e       state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  owner;
    logic [ID_W-1:0]  grant_id;
    logic             any_req;
    logic [CNT_W-1:0] beat_cnt;
    logic             owner_valid;

    accu_rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr),
        .grant_id  (grant_id),
        .any_req   (any_req)
    );

    assign owner_valid = bus.req_valid[owner];

    // Owner's stream is passed straight through to the accumulator while BUSY.
    always_comb begin
        bus.req_ready    = '0;
        bus.acc_valid_in = 1'b0;
        bus.acc_data_in  = '0;
        if (state == BUSY) begin
            bus.req_ready[owner] = 1'b1;
            bus.acc_valid_in     = owner_valid;
            bus.acc_data_in      = bus.req_data[int'(owner)*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            beat_cnt     <= '0;
            bus.res_valid <= 1'b0;
            bus.res_id    <= '0;
            bus.res_data  <= '0;
            proto_err    <= 1'b0;
        end else begin
            bus.res_valid <= 1'b0;
            if (bus.acc_valid_out && state != WAIT_RES) proto_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner <= grant_id;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (owner_valid) begin
                        if (beat_cnt == CNT_W'(GROUP_LEN - 1)) begin
                            beat_cnt <= '0;
                            state    <= WAIT_RES;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                WAIT_RES: begin
                    if (bus.acc_valid_out) begin
                        bus.res_valid <= 1'b1;
                        bus.res_id    <= owner;
                        bus.res_data  <= SUM_W'(bus.acc_data_out);
                        rr_ptr        <= ID_W'(wrap_inc(32'(owner), NUM_REQ));
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ACCU_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grp_cnt <= '0;
        end else if (bus.res_valid) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (bus.res_id == ID_W'(i) && grp_cnt[i*16 +: 16] != 16'hFFFF)
                    grp_cnt[i*16 +: 16] <= grp_cnt[i*16 +: 16] + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_accu_group_arbiter.sv
// Self-checking bench for accu_group_arbiter: directed tables, corner sequences, random vs. reference model.
module tb_accu_group_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic proto_err;
`ifdef ACCU_ARB_STATS_EN
    logic [63:0] grp_cnt;
`endif

    always #5 clk = ~clk;

    accu_group_arbiter_if #(.NUM_REQ(4), .DATA_W(8), .SUM_W(10)) bus ();

    accu_group_arbiter #(.NUM_REQ(4), .DATA_W(8), .SUM_W(10), .GROUP_LEN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
`ifdef ACCU_ARB_STATS_EN
        .grp_cnt   (grp_cnt),
`endif
        .proto_err (proto_err)
    );

    int tests = 0;
    int fails = 0;

    function automatic void chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Accumulator partner: sums 4 beats, pulses the sum one cycle after the 4th beat.
    logic [1:0] acc_cnt;
    logic [9:0] acc_sum;
    logic       acc_vo_q;
    logic [9:0] acc_do_q;
    logic       force_vo = 1'b0;
    logic [9:0] force_do = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt <= '0; acc_sum <= '0; acc_vo_q <= 1'b0; acc_do_q <= '0;
        end else begin
            acc_vo_q <= 1'b0;
            if (bus.acc_valid_in) begin
                if (acc_cnt == 2'd3) begin
                    acc_vo_q <= 1'b1;
                    acc_do_q <= acc_sum + 10'(bus.acc_data_in);
                    acc_sum  <= '0;
                end else begin
                    acc_sum <= acc_sum + 10'(bus.acc_data_in);
                end
                acc_cnt <= acc_cnt + 2'd1;
            end
        end
    end
    assign bus.acc_valid_out = acc_vo_q | force_vo;
    assign bus.acc_data_out  = force_vo ? force_do : acc_do_q;

    // Reference model: transaction view of grants, beats and due-cycle of each result.
    typedef struct { int id; int sum; int due; } exp_t;
    exp_t exp_q[$];
    bit   model_en = 1'b0;
    bit   m_coll;
    int   m_owner, m_cnt, m_sum, m_free_at, m_rr, m_groups;
    int   cyc = 0;
    int   beat_total = 0;

    always @(negedge clk) begin
        int e_ready, e_av, e_ad;
        bit found;
        exp_t e;
        cyc++;
        if (bus.acc_valid_in) beat_total++;
        if (model_en) begin
            e_ready = m_coll ? (1 << m_owner) : 0;
            e_av    = m_coll ? int'(bus.req_valid[2'(m_owner)]) : 0;
            e_ad    = m_coll ? int'(bus.req_data[m_owner*8 +: 8]) : 0;
            chk("rnd_req_ready", int'(bus.req_ready), e_ready);
            chk("rnd_acc_valid_in", int'(bus.acc_valid_in), e_av);
            chk("rnd_acc_data_in", int'(bus.acc_data_in), e_ad);
            if (m_coll) begin
                if (bus.req_valid[2'(m_owner)]) begin
                    m_sum += int'(bus.req_data[m_owner*8 +: 8]);
                    m_cnt++;
                    if (m_cnt == 4) begin
                        m_coll = 1'b0;
                        exp_q.push_back('{m_owner, m_sum % 1024, cyc + 2});
                        m_free_at = cyc + 2;
                        m_rr = (m_owner + 1) % 4;
                    end
                end
            end else if (cyc >= m_free_at && bus.req_valid != '0) begin
                found = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    if (!found && bus.req_valid[2'((m_rr + k) % 4)]) begin
                        found = 1'b1;
                        m_owner = (m_rr + k) % 4;
                    end
                end
                m_coll = 1'b1; m_cnt = 0; m_sum = 0;
            end
            if (bus.res_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_res_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rnd_res_id", int'(bus.res_id), e.id);
                    chk("rnd_res_data", int'(bus.res_data), e.sum);
                    chk("rnd_res_cycle", cyc, e.due);
                    m_groups++;
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                chk("rnd_res_missing", 0, 1);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic set_data(input logic [7:0] base);
        for (int i = 0; i < 4; i++) bus.req_data[i*8 +: 8] = 8'(base + 8'(i));
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        force_vo      = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", int'(bus.req_ready), 0);
        chk("rst_acc_valid_in", int'(bus.acc_valid_in), 0);
        chk("rst_acc_data_in", int'(bus.acc_data_in), 0);
        chk("rst_res_valid", int'(bus.res_valid), 0);
        chk("rst_res_id", int'(bus.res_id), 0);
        chk("rst_res_data", int'(bus.res_data), 0);
        chk("rst_proto_err", int'(proto_err), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_beats(input int n, input int start, input string name);
        for (int c = 0; c < 20 && beat_total - start < n; c++) begin
            @(posedge clk); #1;
        end
        chk(name, beat_total - start, n);
    endtask

    // Runs until a result appears; after 4 beats the valids fall back to keep.
    task automatic wait_res(input int start, input logic [3:0] keep,
                            output int id, output int sum, output bit got);
        got = 1'b0; id = -1; sum = -1;
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge clk); #1;
            if (beat_total - start >= 4) bus.req_valid = keep;
            @(negedge clk);
            if (bus.res_valid) begin
                got = 1'b1;
                id  = int'(bus.res_id);
                sum = int'(bus.res_data);
            end
        end
    endtask

    task automatic run_group(input logic [3:0] mask, input logic [7:0] base,
                             input int exp_id, input int exp_sum, input string tag);
        int start, id, sum;
        bit got;
        start = beat_total;
        bus.req_valid = mask;
        set_data(base);
        wait_res(start, 4'b0000, id, sum, got);
        chk({tag, "_done"}, int'(got), 1);
        if (got) begin
            chk({tag, "_id"}, id, exp_id);
            chk({tag, "_sum"}, sum, exp_sum);
        end
    endtask

    typedef struct { logic [3:0] mask; logic [7:0] base; int exp_id; int exp_sum; } vec_t;
    vec_t vecs[8];

    initial begin
        int start, id, sum, nres;
        bit got;
        int r_id[4], r_sum[4], r_t[4];

        vecs[0] = '{4'b0101,  8'd10, 0,   40};
        vecs[1] = '{4'b0101,  8'd20, 2,   88};
        vecs[2] = '{4'b0011,  8'd60, 0,  240};
        vecs[3] = '{4'b1000, 8'd100, 3,  412};
        vecs[4] = '{4'b1110, 8'd250, 1, 1004};
        vecs[5] = '{4'b1111,   8'd7, 2,   36};
        vecs[6] = '{4'b0110,   8'd3, 1,   16};
        vecs[7] = '{4'b0001, 8'd255, 0, 1020};

        bus.req_valid = '0;
        bus.req_data  = '0;

        // Single requester, beats 1..4, result two cycles after the last beat
        apply_reset();
        bus.req_valid = 4'b0001;
        bus.req_data[7:0] = 8'd1;
        @(negedge clk);
        chk("t1_idle_ready", int'(bus.req_ready), 0);
        chk("t1_idle_acc_valid", int'(bus.acc_valid_in), 0);
        for (int b = 1; b <= 4; b++) begin
            @(negedge clk);
            chk("t1_ready", int'(bus.req_ready), 1);
            chk("t1_beat_valid", int'(bus.acc_valid_in), 1);
            chk("t1_beat_data", int'(bus.acc_data_in), b);
            @(posedge clk); #1;
            if (b < 4) bus.req_data[7:0] = 8'(b + 1);
            else bus.req_valid = '0;
        end
        @(negedge clk);
        chk("t1_wait_res_valid", int'(bus.res_valid), 0);
        chk("t1_wait_ready", int'(bus.req_ready), 0);
        @(negedge clk);
        chk("t1_res_valid", int'(bus.res_valid), 1);
        chk("t1_res_id", int'(bus.res_id), 0);
        chk("t1_res_data", int'(bus.res_data), 10);
        @(negedge clk);
        chk("t1_res_pulse", int'(bus.res_valid), 0);

        // Round-robin table from reset
        apply_reset();
        for (int v = 0; v < 8; v++)
            run_group(vecs[v].mask, vecs[v].base, vecs[v].exp_id, vecs[v].exp_sum, "tbl");

        // Owner stalls mid-group while others request
        apply_reset();
        bus.req_data  = '1;
        bus.req_valid = 4'b0010;
        start = beat_total;
        wait_beats(2, start, "t3_first_beats");
        bus.req_valid = 4'b1101;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t3_stall_ready", int'(bus.req_ready), 2);
            chk("t3_stall_acc_valid", int'(bus.acc_valid_in), 0);
            @(posedge clk); #1;
        end
        bus.req_valid = 4'b1111;
        wait_res(start, 4'b1101, id, sum, got);
        chk("t3_done", int'(got), 1);
        chk("t3_res_id", id, 1);
        chk("t3_res_data", sum, 1020);
        @(negedge clk);
        chk("t3_next_grant", int'(bus.req_ready), 4);

        // All requesters continuously valid for four groups
        apply_reset();
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) bus.req_data[i*8 +: 8] = 8'(16*i + 1);
        start = beat_total;
        nres = 0;
        for (int c = 0; c < 80 && nres < 4; c++) begin
            @(posedge clk); #1;
            if (beat_total - start >= 16) bus.req_valid = '0;
            @(negedge clk);
            if (bus.res_valid) begin
                r_id[nres]  = int'(bus.res_id);
                r_sum[nres] = int'(bus.res_data);
                r_t[nres]   = cyc;
                nres++;
            end
        end
        chk("t4_groups", nres, 4);
        for (int i = 0; i < nres; i++) begin
            chk("t4_res_id", r_id[i], i);
            chk("t4_res_data", r_sum[i], 4*(16*i + 1));
            if (i > 0) chk("t4_period", r_t[i] - r_t[i-1], 6);
        end
`ifdef ACCU_ARB_STATS_EN
        @(negedge clk);
        for (int i = 0; i < 4; i++) chk("t4_grp_cnt", int'(grp_cnt[i*16 +: 16]), 1);
`endif

        // Reset in the middle of a group
        apply_reset();
        bus.req_valid = 4'b1000;
        bus.req_data[31:24] = 8'd50;
        start = beat_total;
        wait_beats(2, start, "t5_first_beats");
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_ready", int'(bus.req_ready), 0);
        chk("t5_rst_acc_valid", int'(bus.acc_valid_in), 0);
        chk("t5_rst_acc_data", int'(bus.acc_data_in), 0);
        chk("t5_rst_res_valid", int'(bus.res_valid), 0);
        @(posedge clk); #1;
        bus.req_valid = '0;
        rst_n = 1'b1;
        run_group(4'b1000, 8'd2, 3, 20, "t5_after");

        // Accumulator pulse outside WAIT_RES
        apply_reset();
        force_do = 10'd77;
        force_vo = 1'b1;
        @(posedge clk); #1;
        force_vo = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("t6_no_res", int'(bus.res_valid), 0);
            chk("t6_proto_err", int'(proto_err), 1);
            @(posedge clk); #1;
        end
        run_group(4'b0001, 8'd9, 0, 36, "t6_group");
        chk("t6_proto_err_sticky", int'(proto_err), 1);
        apply_reset();
        @(negedge clk);
        chk("t6_proto_err_cleared", int'(proto_err), 0);

        // Randomized traffic against the reference model
        apply_reset();
        m_coll = 1'b0; m_rr = 0; m_groups = 0;
        m_free_at = cyc + 1;
        exp_q.delete();
        bus.req_valid = 4'($urandom);
        bus.req_data  = $urandom;
        model_en = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 3) == 0) bus.req_valid[i] = ~bus.req_valid[i];
            bus.req_data = $urandom;
        end
        bus.req_valid = '0;
        repeat (20) @(posedge clk);
        #1;
        chk("rnd_drain", exp_q.size(), 0);
        chk("rnd_enough_groups", int'(m_groups >= 10), 1);
        model_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
